// File: rtl/hazard_ctrl_pkg.sv
// Shared types, defaults and helpers for the decode-stage hazard sequencer.
// State codes are fixed so the encoding can be read straight off a waveform.
package hazard_ctrl_pkg;

  localparam int REG_W            = 3;
  localparam int CNT_W            = 3;
  localparam int DEF_DEPTH        = 3;
  localparam int DEF_BYPASS_RF    = 1;
  localparam int DEF_FLUSH_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     v;
    reg_idx_t dst;
  } sb_entry_t;

  // True when a live entry's destination matches either enabled source.
  function automatic logic src_hit(input sb_entry_t e,
                                   input logic      use_1,
                                   input reg_idx_t  src_1,
                                   input logic      use_2,
                                   input reg_idx_t  src_2);
    return e.v && ((use_1 && (src_1 == e.dst)) || (use_2 && (src_2 == e.dst)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage bundle: the ID instruction fields and EX redirect going in,
// the pipeline steering controls coming back out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic     id_valid;
  reg_idx_t id_rd_reg_1;
  reg_idx_t id_rd_reg_2;
  logic     id_uses_1;
  logic     id_uses_2;
  logic     id_wr_en;
  reg_idx_t id_wr_reg;
  logic     id_halt;
  logic     ex_redirect;

  logic     pc_en;
  logic     stall;
  logic     bubble;
  logic     flush_if_id;
  logic     halted;
  logic     err;

  modport master (
    output id_valid, id_rd_reg_1, id_rd_reg_2, id_uses_1, id_uses_2,
           id_wr_en, id_wr_reg, id_halt, ex_redirect,
    input  pc_en, stall, bubble, flush_if_id, halted, err
  );

  modport slave (
    input  id_valid, id_rd_reg_1, id_rd_reg_2, id_uses_1, id_uses_2,
           id_wr_en, id_wr_reg, id_halt, ex_redirect,
    output pc_en, stall, bubble, flush_if_id, halted, err
  );

endinterface

// File: rtl/hazard_ctrl_sb.sv
// Shift scoreboard of in-flight destination registers; entry 0 is EX.
// Reports per-stage source matches and whether the whole pipe is write-free.
module hazard_ctrl_sb
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BYPASS_RF = DEF_BYPASS_RF
) (
  input  logic             clk,
  input  logic             rst,
  input  sb_entry_t        shift_in,
  input  logic             use_1,
  input  reg_idx_t         src_1,
  input  logic             use_2,
  input  reg_idx_t         src_2,
  output logic [DEPTH-1:0] hazard_vec,
  output logic             all_empty
);

  // With write-before-read regfile the oldest entry has already landed.
  localparam int WINDOW = DEPTH - BYPASS_RF;

  sb_entry_t entry [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      entry[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) begin
        entry[i] <= entry[i-1];
      end
    end
  end

  always_comb begin
    hazard_vec = '0;
    all_empty  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < WINDOW) begin
        hazard_vec[i] = src_hit(entry[i], use_1, src_1, use_2, src_2);
      end
      if (entry[i].v) begin
        all_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: RAW stall/bubble, redirect squash, HALT drain.
//   state  | meaning
//   RUN    | normal issue; stalls on RAW hazard against in-flight writers
//   FLUSH  | squashing wrong-path fetch after an EX redirect
//   DRAIN  | HALT issued; waiting for all in-flight writes to retire
//   HALTED | pipe empty after HALT; only reset leaves
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int BYPASS_RF    = DEF_BYPASS_RF,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FCNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SCNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] scnt;
  logic             err_q;

  logic [DEPTH-1:0] hazard_vec;
  logic             hazard;
  logic             all_empty;
  logic             run;
  logic             stall_c;
  logic             issue;
  sb_entry_t        shift_in;

  assign run     = (state == ST_RUN);
  assign hazard  = |hazard_vec;
  assign stall_c = rst && run && bus.id_valid && hazard && !bus.ex_redirect;
  assign issue   = run && bus.id_valid && !stall_c && !bus.ex_redirect;

  // HALT occupies a slot but never writes, so it cannot block its own drain.
  assign shift_in = '{v: issue && bus.id_wr_en && !bus.id_halt, dst: bus.id_wr_reg};

  hazard_ctrl_sb #(
    .DEPTH     (DEPTH),
    .BYPASS_RF (BYPASS_RF)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .shift_in   (shift_in),
    .use_1      (bus.id_uses_1),
    .src_1      (bus.id_rd_reg_1),
    .use_2      (bus.id_uses_2),
    .src_2      (bus.id_rd_reg_2),
    .hazard_vec (hazard_vec),
    .all_empty  (all_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      fcnt  <= '0;
      scnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (stall_c) begin
        if (scnt != SCNT_MAX) begin
          scnt <= scnt + 1'b1;
        end
        if (scnt == WD_LIMIT) begin
          err_q <= 1'b1;
        end
      end else begin
        scnt <= '0;
      end

      case (state)
        ST_RUN: begin
          if (bus.ex_redirect) begin
            state <= ST_FLUSH;
            fcnt  <= FCNT_INIT;
          end else if (issue && bus.id_halt) begin
            state <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (bus.ex_redirect) begin
            fcnt <= FCNT_INIT;
          end else if (fcnt == '0) begin
            state <= ST_RUN;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          // An older branch redirecting means the HALT itself was wrong-path.
          if (bus.ex_redirect) begin
            state <= ST_FLUSH;
            fcnt  <= FCNT_INIT;
          end else if (all_empty) begin
            state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.stall       = 1'b0;
    bus.bubble      = 1'b1;
    bus.flush_if_id = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN: begin
          bus.stall       = stall_c;
          bus.pc_en       = !stall_c;
          bus.bubble      = stall_c || bus.ex_redirect || !bus.id_valid;
          bus.flush_if_id = bus.ex_redirect;
        end
        ST_FLUSH: begin
          bus.pc_en       = 1'b1;
          bus.flush_if_id = 1'b1;
        end
        default: begin
          bus.pc_en = 1'b0;
        end
      endcase
    end
  end

  assign bus.halted = (state == ST_HALTED);
  assign bus.err    = err_q;

endmodule
